// File: rtl/commu_pkg.sv
// Shared definitions for the commu packet engines: FSM encodings, word-length helper and
// default link timeout.
package commu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_WAIT = 3'd2,
        S_HIGH = 3'd3,
        S_LOW  = 3'd4,
        S_ACK  = 3'd5,
        S_NEXT = 3'd6,
        S_DONE = 3'd7
    } commu_state_e;

    localparam int unsigned TIMEOUT_CYC_DEF = 32'h0000_FFFF;

    // Packets move as 16-bit words; an odd trailing byte is dropped.
    function automatic logic [15:0] lenw(input logic [15:0] len);
        return {1'b0, len[15:1]};
    endfunction

endpackage

// File: rtl/commu_pull.sv
// Receive-side packet engine: pulls len_pkg/2 words from the link receiver and writes them to
// the packet buffer high byte first, with a per-word stall timeout.
module commu_pull
    import commu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        fire_pull,
    output logic        done_pull,
    output logic        err_pull,
    input  logic        fire_rx,
    input  logic [15:0] data_rx,
    output logic        done_rx,
    output logic        buf_wr,
    output logic [7:0]  buf_data,
    output logic        buf_frm,
    input  logic [15:0] len_pkg
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    commu_state_e     state_q, state_d;
    logic [15:0]      data_reg;
    logic [CNT_W-1:0] lenw_reg;
    logic [CNT_W-1:0] cnt_word;
    logic [CNT_W-1:0] cnt_tmo;
    logic             err_flag;
    logic             tmo_hit;

    assign tmo_hit = (cnt_tmo == TMO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (fire_pull) state_d = S_CHK;
            S_CHK:  state_d = (lenw_reg == '0) ? S_DONE : S_WAIT;
            // A word arriving on the expiry cycle still wins over the timeout.
            S_WAIT: begin
                if (fire_rx)      state_d = S_HIGH;
                else if (tmo_hit) state_d = S_DONE;
            end
            S_HIGH: state_d = S_LOW;
            S_LOW:  state_d = S_ACK;
            S_ACK:  state_d = S_NEXT;
            S_NEXT: state_d = (cnt_word == lenw_reg) ? S_DONE : S_WAIT;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            data_reg <= '0;
            lenw_reg <= '0;
            cnt_word <= '0;
            cnt_tmo  <= '0;
            err_flag <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && fire_pull) lenw_reg <= CNT_W'(lenw(len_pkg));
            if (state_q == S_WAIT && fire_rx) data_reg <= data_rx;
            cnt_tmo <= (state_q == S_WAIT && state_d == S_WAIT) ? cnt_tmo + 1'b1 : '0;
            if (state_q == S_ACK)       cnt_word <= cnt_word + 1'b1;
            else if (state_q == S_DONE) cnt_word <= '0;
            if (state_q == S_IDLE) begin
                err_flag <= 1'b0;
            end else if (state_q == S_WAIT && !fire_rx && tmo_hit) begin
                err_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        buf_wr    = (state_q == S_HIGH) || (state_q == S_LOW);
        done_rx   = (state_q == S_ACK);
        done_pull = (state_q == S_DONE);
        err_pull  = (state_q == S_DONE) && err_flag;
        buf_frm   = (state_q != S_IDLE);
        case (state_q)
            S_HIGH:  buf_data = data_reg[15:8];
            S_LOW:   buf_data = data_reg[7:0];
            default: buf_data = 8'h00;
        endcase
    end

endmodule

// File: doc/commu_pull.md
Name: commu_pull

Overview:
Receive-side counterpart of the packet push engine in commu_top. On fire_pull, accepts len_pkg/2 16-bit words from the link receiver, one per fire_rx strobe. Each word is split into two bytes, high byte first, and written to the packet buffer. The engine acknowledges each word to the receiver and signals done_pull at packet end, or err_pull if the link stalls.

Parameters:
TIMEOUT_CYC, 16'hFFFF, max clk_sys cycles spent waiting for one word before abort
CNT_W, 16, width of word counter and timeout counter

Ports:
clk_sys  in  1  system clock, all logic on rising edge
rst_n  in  1  reset; asynchronous, active-low
fire_pull  in  1  start pulse; honoured only in S_IDLE
done_pull  out  1  1-cycle pulse, packet finished (normal or timeout)
err_pull  out  1  1-cycle pulse coincident with done_pull when ended by timeout
fire_rx  in  1  1-cycle strobe, data_rx valid this cycle
data_rx  in  16  received word, {byte0, byte1}
done_rx  out  1  1-cycle ack to receiver, word consumed
buf_wr  out  1  buffer write strobe
buf_data  out  8  buffer write byte
buf_frm  out  1  frame active; high in every state except S_IDLE
len_pkg  in  16  packet length in bytes; sampled on accepted fire_pull

Behaviour:
- Reset values: all outputs 0. FSM in S_IDLE. Counters 0. data_reg = 0. lenw_reg = 0.
- On fire_pull in S_IDLE: lenw_reg <= {1'b0, len_pkg[15:1]}.
  - Odd length: the last byte is not transferred, matching the push side.
- States:
  - S_IDLE: fire_pull -> S_CHK.
  - S_CHK: lenw_reg == 0 -> S_DONE; else -> S_WAIT.
  - S_WAIT: fire_rx -> S_HIGH and latch data_reg <= data_rx. Else, timeout counter == TIMEOUT_CYC-1 -> S_DONE with err flag set.
  - S_HIGH -> S_LOW.
  - S_LOW -> S_ACK.
  - S_ACK -> S_NEXT.
  - S_NEXT: cnt_word == lenw_reg -> S_DONE; else -> S_WAIT.
  - S_DONE -> S_IDLE.
  - Undefined encodings -> S_IDLE.
- Decodes (combinational from state):
  - buf_wr = S_HIGH | S_LOW.
  - buf_data = data_reg[15:8] in S_HIGH, data_reg[7:0] in S_LOW, else 8'h0.
  - done_rx = S_ACK.
  - done_pull = S_DONE.
  - err_pull = S_DONE & err flag.
- Latency: fire_rx at cycle T gives:
  - high-byte write at T+1;
  - low-byte write at T+2;
  - done_rx at T+3;
  - next fire_rx accepted from T+5 (S_WAIT).
- cnt_word:
  - increments in S_ACK;
  - cleared in S_DONE;
  - compared in S_NEXT, so it is never compared mid-increment.
- Timeout counter:
  - counts only in S_WAIT;
  - cleared on any transition out of S_WAIT.
- err flag: set on timeout exit, cleared in S_IDLE.
- fire_rx outside S_WAIT is ignored: no latch, no write, no ack. The receiver must hold off until done_rx.
- fire_pull outside S_IDLE is ignored. len_pkg changes mid-packet have no effect.
- Simultaneous fire_rx and timeout expiry in S_WAIT: fire_rx wins; the word is accepted.
- Reset mid-packet: immediate return to reset values. No partial done_pull. Buffer contents are not the block's concern.
- buf_frm falls the cycle after S_DONE, giving the buffer a frame-end marker.

Decomposition:
- Shared package commu_pkg:
  - state encodings (3-bit S_IDLE..S_DONE, plus S_CHK);
  - LENW(len) halving helper;
  - default TIMEOUT_CYC.
  The same encodings can be reused by commu_push.
- No sub-module. Single flat FSM + datapath of roughly 150–200 lines.

Test Plan:
- len_pkg=4, words 16'hA1B2 then 16'hC3D4 -> buf_data A1,B2,C3,D4 on 4 buf_wr cycles; 2 done_rx pulses; done_pull once; err_pull=0.
- len_pkg=5, single word 16'h1234 then a second word 16'h5678 -> 4 bytes written, 12,34,56,78; done_pull after the 2nd ack; the 5th byte is never requested.
- len_pkg=0, fire_pull -> done_pull exactly 2 cycles after fire_pull; no buf_wr; no done_rx; buf_frm high for 2 cycles.
- TIMEOUT_CYC=8, len_pkg=4, one word then silence -> 2 bytes written; done_pull and err_pull pulse together 8 cycles after entering S_WAIT; FSM back in S_IDLE.
- fire_rx pulses during S_HIGH/S_LOW/S_ACK -> ignored: byte count unchanged, no extra done_rx. A fire_rx coincident with timeout expiry is accepted.
- rst_n asserted during S_LOW of word 1 of 3 -> all outputs 0 on the same edge. A new fire_pull with len_pkg=2 then completes normally with cnt_word starting from 0.
